// File: rtl/gf180mcu_osu_sc_9t_rrarb4_1.sv
// Four-client round-robin arbiter with a hold limit, driving an inverting AND-OR select (Y = ~|(GNT & D)).
// Optional macro GF180_OSU_SC_ARB_PARK_EN: when requests vanish, the grant parks on the last holder.
module gf180mcu_osu_sc_9t_rrarb4_1 #(
    parameter int W       = 1,
    parameter int MAXHOLD = 4,
    parameter int HCW     = 3
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic [3:0]   REQ,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic [W-1:0] D2,
    input  logic [W-1:0] D3,
    output logic [3:0]   GNT,
    output logic         VALID,
    output logic [W-1:0] Y,
    output logic         o_dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t         r_state;
    logic [3:0]     r_gnt;
    logic           r_valid;
    logic [1:0]     r_ptr;
    logic [HCW-1:0] r_hcnt;

    logic [1:0]     w_idx;
    logic [1:0]     w_win_idx;
    logic           w_found;
    logic [3:0]     w_win_oh;
    logic           w_any;
    logic           w_hold;
    logic           w_others;
    logic           w_limit;
    logic [W-1:0]   w_sel;

    // Scan REQ starting at r_ptr; the first requester found wins.
    always_comb begin
        w_idx     = r_ptr;
        w_win_idx = r_ptr;
        w_found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && REQ[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
    end

    assign w_win_oh = 4'b0001 << w_win_idx;
    assign w_any    = |REQ;
    assign w_hold   = |(REQ & r_gnt);
    assign w_others = |(REQ & ~r_gnt);
    // ">=" so a counter that saturated during a solo hold still forces rotation once a rival appears.
    assign w_limit  = (MAXHOLD != 0) && (int'(r_hcnt) >= MAXHOLD - 1);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_ptr   <= 2'd0;
            r_hcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_ptr   <= w_win_idx + 2'd1;
                        r_hcnt  <= '0;
                        r_valid <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!w_hold) begin
                        if (w_any) begin
                            r_gnt   <= w_win_oh;
                            r_ptr   <= w_win_idx + 2'd1;
                            r_hcnt  <= '0;
                            r_valid <= 1'b1;
                        end else begin
`ifdef GF180_OSU_SC_ARB_PARK_EN
                            r_gnt   <= r_gnt;
`else
                            r_gnt   <= 4'b0000;
`endif
                            r_hcnt  <= '0;
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_limit && w_others) begin
                        r_gnt   <= w_win_oh;
                        r_ptr   <= w_win_idx + 2'd1;
                        r_hcnt  <= '0;
                        r_valid <= 1'b1;
                    end else if (r_hcnt != '1) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_sel = ({W{r_gnt[0]}} & D0) | ({W{r_gnt[1]}} & D1) |
                ({W{r_gnt[2]}} & D2) | ({W{r_gnt[3]}} & D3);
    end

    assign Y           = ~w_sel;
    assign GNT         = r_gnt;
    assign VALID       = r_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_rrarb4_1.sv
// Directed bench for the round-robin arbiter: vector table plus hand sequences for reset, rotation, hold and park.
module tb_gf180mcu_osu_sc_9t_rrarb4_1;

    logic       clk;
    logic       rn;
    logic [3:0] req;
    logic [3:0] req_rr;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       valid;
    logic [0:0] y;
    logic       dbg;
    logic [3:0] gnt_rr;
    logic       valid_rr;
    logic [0:0] y_rr;
    logic       dbg_rr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic       valid;
        logic       y;
    } vec_t;

    vec_t vecs[12];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    gf180mcu_osu_sc_9t_rrarb4_1 #(.W(1), .MAXHOLD(4), .HCW(3)) u_dut (
        .CLK(clk), .RN(rn), .REQ(req),
        .D0(d[0:0]), .D1(d[1:1]), .D2(d[2:2]), .D3(d[3:3]),
        .GNT(gnt), .VALID(valid), .Y(y), .o_dbg_state(dbg)
    );

    gf180mcu_osu_sc_9t_rrarb4_1 #(.W(1), .MAXHOLD(1), .HCW(3)) u_rr (
        .CLK(clk), .RN(rn), .REQ(req_rr),
        .D0(d[0:0]), .D1(d[1:1]), .D2(d[2:2]), .D3(d[3:3]),
        .GNT(gnt_rr), .VALID(valid_rr), .Y(y_rr), .o_dbg_state(dbg_rr)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rn = 1'b0;
        @(posedge clk);
        #1;
        rn = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] eg, input logic ev, input logic ey);
        check({name, ".gnt"},   {4'b0, gnt},   {4'b0, eg});
        check({name, ".valid"}, {7'b0, valid}, {7'b0, ev});
        check({name, ".y"},     {7'b0, y},     {7'b0, ey});
    endtask

    initial begin
        vecs[0]  = '{4'b1110, 4'b0011, 4'b0010, 1'b1, 1'b0};
        vecs[1]  = '{4'b1010, 4'b0001, 4'b0010, 1'b1, 1'b1};
        vecs[2]  = '{4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b1};
        vecs[3]  = '{4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{4'b1010, 4'b0010, 4'b1000, 1'b1, 1'b1};
        vecs[5]  = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 1'b0};
        vecs[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1};
        vecs[7]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b0};
        vecs[8]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b0};
        vecs[9]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b0};
        vecs[10] = '{4'b0101, 4'b0100, 4'b0001, 1'b1, 1'b1};
        vecs[11] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0};

        // Reset with all requests asserted.
        rn = 1'b0; req = 4'b1111; req_rr = 4'b1111; d = 4'b1111;
        @(posedge clk); @(posedge clk); #1;
        check_out("reset", 4'b0000, 1'b0, 1'b1);
        check("reset_rr.gnt", {4'b0, gnt_rr}, 8'h00);
        check("reset_rr.valid", {7'b0, valid_rr}, 8'h00);
        check("reset_rr.y", {7'b0, y_rr}, 8'h01);
        rn = 1'b1;
        step(4'b1111);
        check_out("first_grant", 4'b0001, 1'b1, 1'b0);

        // Vector table: handoffs, hold limit, pointer wrap, AOI output.
        for (int i = 0; i < 12; i++) begin
            d = vecs[i].d;
            step(vecs[i].req);
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].y);
        end

        // Round robin with MAXHOLD=1: rotates every edge.
        req_rr = 4'b1111;
        pulse_reset();
        step(4'b0000);
        check("rr0", {4'b0, gnt_rr}, 8'b0000_0001);
        check("rr0.valid", {7'b0, valid_rr}, 8'h01);
        step(4'b0000);
        check("rr1", {4'b0, gnt_rr}, 8'b0000_0010);
        step(4'b0000);
        check("rr2", {4'b0, gnt_rr}, 8'b0000_0100);
        step(4'b0000);
        check("rr3", {4'b0, gnt_rr}, 8'b0000_1000);
        step(4'b0000);
        check("rr4", {4'b0, gnt_rr}, 8'b0000_0001);
        req_rr = 4'b0000;

        // Hold limit: 0001 then 0011 -> four cycles of 0001, then 0010.
        d = 4'b0000;
        pulse_reset();
        step(4'b0001);
        check_out("hold0", 4'b0001, 1'b1, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step(4'b0011);
            check_out($sformatf("hold%0d", i), 4'b0001, 1'b1, 1'b1);
        end
        step(4'b0011);
        check_out("hold_rot", 4'b0010, 1'b1, 1'b1);

        // Combinational AOI path while GNT=0010.
        d = 4'b0010; #1;
        check("aoi_d1_hi", {7'b0, y}, 8'h00);
        d = 4'b0000; #1;
        check("aoi_d1_lo", {7'b0, y}, 8'h01);
        d = 4'b0001; #1;
        check("aoi_d0_tog1", {7'b0, y}, 8'h01);
        d = 4'b0000; #1;
        check("aoi_d0_tog0", {7'b0, y}, 8'h01);

        // Sole requester keeps the grant for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step(4'b0100);
            check($sformatf("sole%0d.gnt", i), {4'b0, gnt}, 8'b0000_0100);
            check($sformatf("sole%0d.valid", i), {7'b0, valid}, 8'h01);
        end

        // Mid-grant asynchronous reset while GNT=1000.
        d = 4'b1000;
        step(4'b1000);
        check_out("pre_rst", 4'b1000, 1'b1, 1'b0);
        #2 rn = 1'b0;
        #1;
        check_out("async_rst", 4'b0000, 1'b0, 1'b1);

        // Release reset, grant client 0, then drop all requests.
        d = 4'b0001;
        req = 4'b0001;
        #1 rn = 1'b1;
        step(4'b0001);
        check_out("park_grant", 4'b0001, 1'b1, 1'b0);
        step(4'b0000);
`ifdef GF180_OSU_SC_ARB_PARK_EN
        check_out("park_idle", 4'b0001, 1'b0, 1'b0);
`else
        check_out("park_idle", 4'b0000, 1'b0, 1'b1);
`endif
        step(4'b0010);
        check_out("after_idle", 4'b0010, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gf180mcu_osu_sc_9t_rrarb4_1.md
Name: gf180mcu_osu_sc_9T_rrarb4_1

Overview:
- Four-requester round-robin arbiter with hold-limit counter.
- Shares one inverted AND-OR select path (AOI22-style, W bits wide) between four data sources.
- Drives the one-hot grant into the inverting mux: Y = ~(OR over i of GNT[i] & Di).
- Used where several cell-level clients share a single inverting bus or mux leg in the 9T library flow.

Parameters:
- W, 1, data width of D0..D3 and Y.
- MAXHOLD, 4, max consecutive grant cycles for one requester while others wait. 0 = unlimited.
- HCW, 3, hold-counter width. Must satisfy 2^HCW >= MAXHOLD.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- REQ  input  4  request per client. Level, held until done.
- D0  input  W  client 0 data.
- D1  input  W  client 1 data.
- D2  input  W  client 2 data.
- D3  input  W  client 3 data.
- GNT  output  4  registered one-hot grant. All-zero when idle.
- VALID  output  1  registered. High when GNT is nonzero and that client was requesting at the grant edge.
- Y  output  W  combinational ~(OR over i of GNT[i] & Di). All ones when GNT = 0.

Behaviour:
- Reset (RN low, asynchronous): GNT=0000, VALID=0, priority pointer PTR=0, hold counter HCNT=0, Y=all ones. Reset mid-grant drops the grant immediately, no drain. First arbitration is the first CLK edge after RN rises.
- State IDLE: GNT=0.
  - On an edge with REQ != 0, grant the first requesting index scanning PTR, PTR+1, ... (mod 4).
  - Set PTR = winner+1 mod 4, HCNT=0, VALID=1. Move to BUSY.
- State BUSY: holder g = index of GNT. Evaluated each edge.
  - REQ[g]=0: re-arbitrate this same edge among current REQ using PTR. No idle bubble. If REQ=0, go to IDLE (GNT=0, VALID=0).
  - REQ[g]=1, MAXHOLD != 0, HCNT == MAXHOLD-1, and any other REQ high: forced rotation. Grant the next requester from PTR. g is lowest priority because PTR = g+1. HCNT=0.
  - Otherwise keep grant. HCNT increments, saturating at 2^HCW-1. If no other requester is waiting, the holder keeps the grant indefinitely.
- Latency: REQ rise to GNT is 1 cycle. REQ fall to grant release is 1 cycle. Y follows D and GNT combinationally, zero cycles.
- Grant is always one-hot or zero. A back-to-back switch changes GNT in a single edge.
- Simultaneous release by the holder and new requests: the new winner is chosen the same edge.
- PTR wraps from 3 to 0. PTR changes only when a new grant is issued.
- X on REQ during reset has no effect. After reset, REQ must be known.

Optional Feature:
- Macro: GF180_OSU_SC_ARB_PARK_EN.
- Defined: when arbitration finds REQ=0, GNT parks on the last holder (stays one-hot) with VALID=0, HCNT=0. Y keeps following that client's data. A new request is granted next edge per the normal PTR rule. After reset, GNT=0 until the first grant.
- Undefined: GNT returns to 0000 and Y to all ones, as specified above.

Test Plan:
- Reset: RN low with REQ=1111 -> GNT=0000, VALID=0, Y=all ones. RN high -> the next edge gives GNT=0001 and VALID=1.
- Round-robin: REQ=1111 held, MAXHOLD=1 -> GNT sequence 0001, 0010, 0100, 1000, 0001 on consecutive edges.
- Hold limit: MAXHOLD=4, REQ=0001 then REQ=0011 from the next edge -> GNT=0001 for 4 cycles, then 0010.
- Sole requester: REQ=0100 for 20 cycles -> GNT=0100 throughout, no forced rotation, VALID=1.
- AOI path, W=1: GNT=0010 with D1=1 -> Y=0. With D1=0 -> Y=1. Toggling D0 while GNT=0010 leaves Y unchanged.
- Mid-grant reset and park: RN pulsed low while GNT=1000 -> GNT=0000 asynchronously. With the PARK macro, REQ 0001→0000 -> GNT stays 0001, VALID=0.
